stream_rr_arb: RTL

STREAM_RR_ARB -- requirements
Module: stream_rr_arb

---
 rtl/stream_rr_arb.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/stream_rr_arb.sv
// Round-robin burst arbiter: merges NUM_REQ forward token streams into one
// downstream buffer, holding each grant for up to BURST_LEN beats.
package pkg_en;
    typedef struct packed {
        logic        v;
        logic [15:0] d;
    } FTk_t;

    typedef struct packed {
        logic n;
        logic t;
        logic v;
        logic c;
    } BTk_t;
endpackage

module stream_rr_arb #(
    parameter int  NUM_REQ   = 4,
    parameter int  BURST_LEN = 8,
    parameter type TYPE_FWRD = pkg_en::FTk_t
) (
    input  logic                clock,
    input  logic                reset,
    input  TYPE_FWRD            I_FTk [NUM_REQ],
    output pkg_en::BTk_t        O_BTk [NUM_REQ],
    output TYPE_FWRD            O_FTk,
    input  pkg_en::BTk_t        I_BTk,
    output logic [NUM_REQ-1:0]  O_Grant,
    output logic                O_Busy
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(BURST_LEN) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, STALL, RELEASE} state_t;

    state_t              state_reg, state_next;
    logic [NUM_REQ-1:0]  grant_reg, grant_next;
    logic [PW-1:0]       ptr_reg, ptr_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [1:0]          nack_hist_reg, nack_hist_next;

    logic [NUM_REQ-1:0]  req_valid;
    logic [PW-1:0]       rr_idx;
    logic                rr_found;
    logic [PW-1:0]       grant_idx;
    logic                gnt_valid;
    logic                transfer;
    logic                holding;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_valid
            assign req_valid[gi] = I_FTk[gi].v;
        end
    endgenerate

    // Search starts just after the last owner so every requester gets a turn.
    always_comb begin
        int cand;
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(ptr_reg) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!rr_found && req_valid[PW'(cand)]) begin
                rr_found = 1'b1;
                rr_idx   = PW'(cand);
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_reg[i]) grant_idx = PW'(i);
        end
    end

    assign gnt_valid = |(grant_reg & req_valid);
    assign transfer  = (state_reg == BUSY) && gnt_valid && !I_BTk.n;
    assign holding   = (state_reg == BUSY) || (state_reg == STALL);

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        ptr_next       = ptr_reg;
        cnt_next       = cnt_reg;
        nack_hist_next = nack_hist_reg;
        case (state_reg)
            IDLE: begin
                if (rr_found) begin
                    grant_next         = '0;
                    grant_next[rr_idx] = 1'b1;
                    cnt_next           = '0;
                    state_next         = BUSY;
                end
            end
            BUSY: begin
                if (I_BTk.n) begin
                    // Stall entry counts as a Nack already seen.
                    nack_hist_next = 2'b11;
                    state_next     = STALL;
                end else if (gnt_valid) begin
                    cnt_next = cnt_reg + CW'(1);
                    if (cnt_reg == CW'(BURST_LEN - 1)) state_next = RELEASE;
                end else begin
                    state_next = RELEASE;
                end
            end
            STALL: begin
                nack_hist_next = {nack_hist_reg[0], I_BTk.n};
                if (!I_BTk.n && !nack_hist_reg[0]) state_next = BUSY;
            end
            RELEASE: begin
                ptr_next   = grant_idx;
                grant_next = '0;
                cnt_next   = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            ptr_reg       <= PW'(NUM_REQ - 1);
            cnt_reg       <= '0;
            nack_hist_reg <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            ptr_reg       <= ptr_next;
            cnt_reg       <= cnt_next;
            nack_hist_reg <= nack_hist_next;
        end
    end

    assign O_FTk   = transfer ? I_FTk[grant_idx] : '0;
    assign O_Grant = grant_reg;
    assign O_Busy  = holding;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            O_BTk[i]   = '0;
            O_BTk[i].n = 1'b1;
            if (holding && grant_reg[i]) begin
                O_BTk[i].n = I_BTk.n | (state_reg == STALL);
                O_BTk[i].t = I_BTk.t;
                O_BTk[i].v = I_BTk.v;
                O_BTk[i].c = I_BTk.c;
            end
        end
    end
endmodule
